// File: rtl/mac_seq.sv
// Sequential sign-magnitude dot product: N_TERMS (a, w) pairs streamed LANES per beat,
// positive and negative products accumulated apart, one registered result per transaction.
module mac_seq #(
    parameter int N_TERMS = 62,
    parameter int LANES   = 2,
    parameter int MAG_W   = 7,
    parameter int ACC_W   = 2*MAG_W + $clog2(N_TERMS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LANES*(MAG_W+1)-1:0] in_a,
    input  logic [LANES*(MAG_W+1)-1:0] in_w,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [ACC_W:0]             out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy
);
    localparam int OP_W  = MAG_W + 1;
    localparam int BEATS = (N_TERMS + LANES - 1) / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_r;
    logic [ACC_W-1:0] pos_r;
    logic [ACC_W-1:0] neg_r;
    logic [CNT_W-1:0] beat_cnt_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic [ACC_W:0]   out_r;
    logic [ACC_W-1:0] pos_add_s;
    logic [ACC_W-1:0] neg_add_s;
    logic [ACC_W:0]   result_s;
    logic             xfer_s;

    function automatic logic [2*MAG_W-1:0] lane_prod(input logic [OP_W-1:0] a,
                                                     input logic [OP_W-1:0] w);
        return {{MAG_W{1'b0}}, a[MAG_W-1:0]} * {{MAG_W{1'b0}}, w[MAG_W-1:0]};
    endfunction

    assign xfer_s    = in_valid & in_ready_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out       = out_r;

    // Sum this beat's lane products by product sign; lanes past N_TERMS are padding.
    always_comb begin
        pos_add_s = {ACC_W{1'b0}};
        neg_add_s = {ACC_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if ((int'(beat_cnt_r) * LANES + i) < N_TERMS) begin
                if (in_a[OP_W*i + MAG_W] ^ in_w[OP_W*i + MAG_W]) begin
                    neg_add_s = neg_add_s + ACC_W'(lane_prod(in_a[OP_W*i +: OP_W], in_w[OP_W*i +: OP_W]));
                end else begin
                    pos_add_s = pos_add_s + ACC_W'(lane_prod(in_a[OP_W*i +: OP_W], in_w[OP_W*i +: OP_W]));
                end
            end else begin
                pos_add_s = pos_add_s;
            end
        end
    end

    // Signed difference of the two accumulators; a tie yields positive zero.
    always_comb begin
        if (pos_r > neg_r) begin
            result_s = {1'b0, pos_r - neg_r};
        end else if (neg_r > pos_r) begin
            result_s = {1'b1, neg_r - pos_r};
        end else begin
            result_s = {(ACC_W+1){1'b0}};
        end
    end

    // Transaction sequencer with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            pos_r       <= {ACC_W{1'b0}};
            neg_r       <= {ACC_W{1'b0}};
            beat_cnt_r  <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            out_r       <= {(ACC_W+1){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        pos_r      <= {ACC_W{1'b0}};
                        neg_r      <= {ACC_W{1'b0}};
                        beat_cnt_r <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (xfer_s) begin
                        pos_r      <= pos_r + pos_add_s;
                        neg_r      <= neg_r + neg_add_s;
                        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                        if (beat_cnt_r == LAST_BEAT) begin
                            in_ready_r <= 1'b0;
                            state_r    <= FIN;
                        end
                    end
                end
                FIN: begin
                    out_r       <= result_s;
                    out_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq: three instances (defaults, 4 terms, 5 terms) sharing the
// beat bus, each scenario task comparing against hand-computed or modelled results.
module tb_mac_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_d, start_4, start_5;
    logic [15:0] in_a, in_w;
    logic        in_valid, out_ready;

    logic        rdy_d, ov_d, busy_d;
    logic [20:0] out_d;
    logic        rdy_4, ov_4, busy_4;
    logic [16:0] out_4;
    logic        rdy_5, ov_5, busy_5;
    logic [17:0] out_5;

    int          sel = 0;
    logic        cur_rdy, cur_ov, cur_busy, cur_sign;
    logic [19:0] cur_mag;

    logic [7:0]  pa [0:63];
    logic [7:0]  pw [0:63];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_seq u_def (
        .clk(clk), .rst(rst), .start(start_d), .in_a(in_a), .in_w(in_w),
        .in_valid(in_valid), .in_ready(rdy_d), .out(out_d), .out_valid(ov_d),
        .out_ready(out_ready), .busy(busy_d)
    );

    mac_seq #(.N_TERMS(4), .LANES(2), .MAG_W(7)) u_n4 (
        .clk(clk), .rst(rst), .start(start_4), .in_a(in_a), .in_w(in_w),
        .in_valid(in_valid), .in_ready(rdy_4), .out(out_4), .out_valid(ov_4),
        .out_ready(out_ready), .busy(busy_4)
    );

    mac_seq #(.N_TERMS(5), .LANES(2), .MAG_W(7)) u_n5 (
        .clk(clk), .rst(rst), .start(start_5), .in_a(in_a), .in_w(in_w),
        .in_valid(in_valid), .in_ready(rdy_5), .out(out_5), .out_valid(ov_5),
        .out_ready(out_ready), .busy(busy_5)
    );

    // View of whichever instance the running scenario targets.
    always_comb begin
        case (sel)
            1: begin
                cur_rdy = rdy_4; cur_ov = ov_4; cur_busy = busy_4;
                cur_sign = out_4[16]; cur_mag = 20'(out_4[15:0]);
            end
            2: begin
                cur_rdy = rdy_5; cur_ov = ov_5; cur_busy = busy_5;
                cur_sign = out_5[17]; cur_mag = 20'(out_5[16:0]);
            end
            default: begin
                cur_rdy = rdy_d; cur_ov = ov_d; cur_busy = busy_d;
                cur_sign = out_d[20]; cur_mag = out_d[19:0];
            end
        endcase
    end

    function automatic logic [7:0] sm(input int v);
        logic [7:0] r;
        r[7]   = (v < 0);
        r[6:0] = (v < 0) ? 7'(-v) : 7'(v);
        return r;
    endfunction

    // Signed reference dot product over the first n stored pairs.
    function automatic int model(input int n);
        int s = 0;
        for (int k = 0; k < n; k++) begin
            int p = int'(pa[k][6:0]) * int'(pw[k][6:0]);
            s = (pa[k][7] ^ pw[k][7]) ? s - p : s + p;
        end
        return s;
    endfunction

    task automatic drive_start(input logic v);
        start_d = (sel == 0) ? v : 1'b0;
        start_4 = (sel == 1) ? v : 1'b0;
        start_5 = (sel == 2) ? v : 1'b0;
    endtask

    // Drive one transaction on the selected instance and capture what it returns.
    task automatic run_txn(input int n, input bit stress, input bit hold_low,
                           output logic sign, output logic [19:0] mag, output int lat,
                           output int hold_bad, output logic after_ov, output logic [20:0] after_out);
        int beats = (n + 1) / 2;
        int b = 0;
        int guard = 0;
        logic [20:0] held;
        out_ready = hold_low ? 1'b0 : 1'b1;
        @(negedge clk);
        drive_start(1'b1);
        while (b < beats && guard < 2000) begin
            @(negedge clk);
            guard++;
            drive_start(stress && guard == 4);
            if (stress && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_a = 16'($urandom);
                in_w = 16'($urandom);
            end else begin
                in_valid = 1'b1;
                in_a = {pa[2*b+1], pa[2*b]};
                in_w = {pw[2*b+1], pw[2*b]};
                if (cur_rdy) b++;
            end
        end
        drive_start(1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            in_a = 16'($urandom);
            in_w = 16'($urandom);
            lat++;
        end while (!cur_ov && lat < 50);
        sign = cur_sign;
        mag = cur_mag;
        held = {sign, mag};
        hold_bad = 0;
        if (hold_low) begin
            repeat (10) begin
                @(negedge clk);
                if (!cur_ov || {cur_sign, cur_mag} !== held) hold_bad++;
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        after_ov = cur_ov;
        after_out = {cur_sign, cur_mag};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_a = 16'd0;
        in_w = 16'd0;
        start_d = 1'b0; start_4 = 1'b0; start_5 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rdy_d, ov_d, busy_d} !== 3'b000 || out_d !== 21'd0) begin
            errors++; $display("FAIL reset_def got rdy/ov/busy=%b%b%b out=%0d want 000/0", rdy_d, ov_d, busy_d, out_d);
        end
        checks++;
        if ({rdy_4, ov_4, busy_4} !== 3'b000 || out_4 !== 17'd0) begin
            errors++; $display("FAIL reset_n4 got rdy/ov/busy=%b%b%b out=%0d want 000/0", rdy_4, ov_4, busy_4, out_4);
        end
        checks++;
        if ({rdy_5, ov_5, busy_5} !== 3'b000 || out_5 !== 18'd0) begin
            errors++; $display("FAIL reset_n5 got rdy/ov/busy=%b%b%b out=%0d want 000/0", rdy_5, ov_5, busy_5, out_5);
        end
        rst = 1'b0;
    endtask

    task automatic test_mixed();
        logic sg, aov; logic [19:0] mg; logic [20:0] aout; int lat, hb;
        sel = 1;
        pa[0] = sm(100);  pw[0] = sm(-5);
        pa[1] = sm(93);   pw[1] = sm(4);
        pa[2] = sm(-103); pw[2] = sm(-3);
        pa[3] = sm(-127); pw[3] = sm(2);
        run_txn(4, 1'b0, 1'b0, sg, mg, lat, hb, aov, aout);
        checks++;
        if (sg !== 1'b1 || mg !== 20'd73) begin
            errors++; $display("FAIL mixed_result got %b/%0d want 1/73", sg, mg);
        end
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL mixed_latency got %0d want 2", lat);
        end
        checks++;
        if (aov !== 1'b0) begin
            errors++; $display("FAIL mixed_valid_width got out_valid=%b after accept want 0", aov);
        end
        checks++;
        if (aout !== {1'b1, 20'd73}) begin
            errors++; $display("FAIL mixed_out_kept got %h want %h", aout, {1'b1, 20'd73});
        end
    endtask

    task automatic test_zero();
        logic sg, aov; logic [19:0] mg; logic [20:0] aout; int lat, hb;
        sel = 1;
        pa[0] = sm(10);  pw[0] = sm(10);
        pa[1] = sm(-10); pw[1] = sm(10);
        pa[2] = 8'h80;   pw[2] = sm(5);
        pa[3] = sm(7);   pw[3] = 8'h80;
        run_txn(4, 1'b0, 1'b0, sg, mg, lat, hb, aov, aout);
        checks++;
        if (sg !== 1'b0 || mg !== 20'd0) begin
            errors++; $display("FAIL zero_result got %b/%0d want 0/0", sg, mg);
        end
    endtask

    task automatic test_full_scale();
        logic sg, aov; logic [19:0] mg; logic [20:0] aout; int lat, hb;
        sel = 0;
        for (int k = 0; k < 62; k++) begin pa[k] = sm(127); pw[k] = sm(127); end
        run_txn(62, 1'b0, 1'b0, sg, mg, lat, hb, aov, aout);
        checks++;
        if (sg !== 1'b0 || mg !== 20'd999998) begin
            errors++; $display("FAIL full_pos got %b/%0d want 0/999998", sg, mg);
        end
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL full_latency got %0d want 2", lat);
        end
        for (int k = 0; k < 62; k++) begin pa[k] = sm(-127); end
        run_txn(62, 1'b0, 1'b0, sg, mg, lat, hb, aov, aout);
        checks++;
        if (sg !== 1'b1 || mg !== 20'd999998) begin
            errors++; $display("FAIL full_neg got %b/%0d want 1/999998", sg, mg);
        end
    endtask

    task automatic test_partial();
        logic sg, aov; logic [19:0] mg; logic [20:0] aout; int lat, hb;
        sel = 2;
        for (int k = 0; k < 5; k++) begin pa[k] = sm(1); pw[k] = sm(1); end
        pa[5] = sm(127); pw[5] = sm(127);
        run_txn(5, 1'b0, 1'b0, sg, mg, lat, hb, aov, aout);
        checks++;
        if (sg !== 1'b0 || mg !== 20'd5) begin
            errors++; $display("FAIL partial_result got %b/%0d want 0/5", sg, mg);
        end
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL partial_latency got %0d want 2", lat);
        end
    endtask

    task automatic test_handshake_stress();
        logic sg, aov; logic [19:0] mg; logic [20:0] aout; int lat, hb, exp;
        sel = 0;
        for (int k = 0; k < 62; k++) begin
            pa[k] = 8'($urandom);
            pw[k] = 8'($urandom);
            if (k % 9 == 0) pa[k] = 8'h80;
        end
        exp = model(62);
        run_txn(62, 1'b1, 1'b1, sg, mg, lat, hb, aov, aout);
        checks++;
        if (sg !== (exp < 0) || mg !== 20'((exp < 0) ? -exp : exp)) begin
            errors++; $display("FAIL stress_result got %b/%0d want model %0d", sg, mg, exp);
        end
        checks++;
        if (hb !== 0) begin
            errors++; $display("FAIL stress_hold got %0d unstable cycles want 0", hb);
        end
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL stress_latency got %0d want 2", lat);
        end
        checks++;
        if (aov !== 1'b0) begin
            errors++; $display("FAIL stress_release got out_valid=%b want 0", aov);
        end
    endtask

    task automatic test_reset_mid();
        logic sg, aov; logic [19:0] mg; logic [20:0] aout; int lat, hb, exp;
        sel = 0;
        out_ready = 1'b1;
        @(negedge clk);
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        in_valid = 1'b1;
        in_a = {pa[1], pa[0]}; in_w = {pw[1], pw[0]};
        @(negedge clk);
        in_a = {pa[3], pa[2]}; in_w = {pw[3], pw[2]};
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy_d !== 1'b1 || rdy_d !== 1'b1) begin
            errors++; $display("FAIL midrun_busy got busy=%b rdy=%b want 1/1", busy_d, rdy_d);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy_d, ov_d, busy_d} !== 3'b000 || out_d !== 21'd0) begin
            errors++; $display("FAIL midrun_reset got rdy/ov/busy=%b%b%b out=%0d want 000/0", rdy_d, ov_d, busy_d, out_d);
        end
        rst = 1'b0;
        for (int k = 0; k < 62; k++) begin
            pa[k] = sm(k + 3);
            pw[k] = sm(((k * 7) % 41) - 20);
        end
        exp = model(62);
        run_txn(62, 1'b0, 1'b0, sg, mg, lat, hb, aov, aout);
        checks++;
        if (sg !== (exp < 0) || mg !== 20'((exp < 0) ? -exp : exp)) begin
            errors++; $display("FAIL fresh_after_reset got %b/%0d want model %0d", sg, mg, exp);
        end
    endtask

    initial begin
        test_reset();
        test_mixed();
        test_zero();
        test_full_scale();
        test_partial();
        test_handshake_stress();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
endmodule
